// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : flag_branch_unit
//  Description : Architectural Z/V/N flag register fed by the EX-stage ALU,
//                branch-condition resolver for the ID stage with optional
//                EX-to-ID flag forwarding, and sticky HLT retirement latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_unit #(
   parameter logic [2:0] FLAG_RESET    = 3'b000,
   parameter bit         FORWARD_FLAGS = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ex_valid,
   input  logic [3:0] ex_opcode,
   input  logic [2:0] alu_flags,
   input  logic       stall,
   input  logic       flush,
   input  logic       br_valid,
   input  logic [2:0] br_cond,
   output logic [2:0] flags_q,
   output logic       br_taken,
   output logic       flag_hazard,
   output logic       halted
);

   // Opcodes that matter to this block
   localparam logic [3:0] c_op_add = 4'b0000;
   localparam logic [3:0] c_op_sub = 4'b0001;
   localparam logic [3:0] c_op_xor = 4'b0010;
   localparam logic [3:0] c_op_sll = 4'b0100;
   localparam logic [3:0] c_op_sra = 4'b0101;
   localparam logic [3:0] c_op_ror = 4'b0110;
   localparam logic [3:0] c_op_hlt = 4'b1111;

   // Branch condition codes (ccc field)
   localparam logic [2:0] c_cc_ne = 3'b000;
   localparam logic [2:0] c_cc_eq = 3'b001;
   localparam logic [2:0] c_cc_gt = 3'b010;
   localparam logic [2:0] c_cc_lt = 3'b011;
   localparam logic [2:0] c_cc_ge = 3'b100;
   localparam logic [2:0] c_cc_le = 3'b101;
   localparam logic [2:0] c_cc_ov = 3'b110;
   localparam logic [2:0] c_cc_al = 3'b111;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t     r_state;
   logic [2:0] r_flags;

   logic [2:0] w_mask;
   logic       w_commit;
   logic       w_writes_flags;
   logic [2:0] w_eff;
   logic       w_cond;
   logic       w_halted;
   logic       w_hazard;

   assign w_halted = (r_state == ST_HALTED);
   assign w_commit = ex_valid & ~stall & ~flush & ~w_halted;

   // Per-opcode flag write mask, bit order {Z,V,N}
   always_comb begin
      w_mask = 3'b000;
      case (ex_opcode)
         c_op_add, c_op_sub:                     w_mask = 3'b111;
         c_op_xor, c_op_sll, c_op_sra, c_op_ror: w_mask = 3'b100;
         default:                                w_mask = 3'b000;
      endcase
   end

   // A flush squashes the write, but a stall does not hide a pending write
   assign w_writes_flags = ex_valid & ~flush & (w_mask != 3'b000);

   // Flags seen by the branch: forwarded EX result overlays the register
   always_comb begin
      w_eff = r_flags;
      if (FORWARD_FLAGS && w_writes_flags)
         w_eff = (r_flags & ~w_mask) | (alu_flags & w_mask);
   end

   // Evaluate the ID-stage branch condition against the effective flags
   always_comb begin
      w_cond = 1'b0;
      case (br_cond)
         c_cc_ne: w_cond = ~w_eff[2];
         c_cc_eq: w_cond =  w_eff[2];
         c_cc_gt: w_cond = ~w_eff[2] & ~w_eff[0];
         c_cc_lt: w_cond =  w_eff[0];
         c_cc_ge: w_cond =  w_eff[2] | (~w_eff[2] & ~w_eff[0]);
         c_cc_le: w_cond =  w_eff[0] | w_eff[2];
         c_cc_ov: w_cond =  w_eff[1];
         c_cc_al: w_cond =  1'b1;
         default: w_cond =  1'b0;
      endcase
   end

   // Unconditional branches never depend on flags, so they never stall
   assign w_hazard = ~FORWARD_FLAGS & br_valid & w_writes_flags &
                     (br_cond != c_cc_al) & ~w_halted & ~rst;

   assign flag_hazard = w_hazard;
   assign br_taken    = br_valid & ~w_hazard & ~w_halted & ~rst & w_cond;
   assign flags_q     = r_flags;
   assign halted      = w_halted;

   // Flag register update and RUN/HALTED sequencing; reset drops any pending write
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flags <= FLAG_RESET;
         r_state <= ST_RUN;
      end else begin
         if (w_commit)
            r_flags <= (r_flags & ~w_mask) | (alu_flags & w_mask);
         case (r_state)
            ST_RUN:    if (w_commit && (ex_opcode == c_op_hlt)) r_state <= ST_HALTED;
            ST_HALTED: r_state <= ST_HALTED;
            default:   r_state <= ST_RUN;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flag_branch_unit
//  Description : Directed bench for flag_branch_unit; instance u_nf runs with
//                stall-on-hazard, u_fw with flag forwarding, inputs shared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_branch_unit;

   logic       clk;
   logic       rst;
   logic       ex_valid;
   logic [3:0] ex_opcode;
   logic [2:0] alu_flags;
   logic       stall;
   logic       flush;
   logic       br_valid;
   logic [2:0] br_cond;

   logic [2:0] nf_flags, fw_flags;
   logic       nf_taken, fw_taken;
   logic       nf_haz, fw_haz;
   logic       nf_halt, fw_halt;

   int checks = 0;
   int errors = 0;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_HLT = 4'b1111;

   flag_branch_unit #(.FLAG_RESET(3'b000), .FORWARD_FLAGS(1'b0)) u_nf (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .alu_flags(alu_flags), .stall(stall), .flush(flush),
      .br_valid(br_valid), .br_cond(br_cond),
      .flags_q(nf_flags), .br_taken(nf_taken), .flag_hazard(nf_haz), .halted(nf_halt)
   );

   flag_branch_unit #(.FLAG_RESET(3'b000), .FORWARD_FLAGS(1'b1)) u_fw (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .alu_flags(alu_flags), .stall(stall), .flush(flush),
      .br_valid(br_valid), .br_cond(br_cond),
      .flags_q(fw_flags), .br_taken(fw_taken), .flag_hazard(fw_haz), .halted(fw_halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // Inputs change at the falling edge; combinational outputs checked 1 ns later
   task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] af,
                        input logic st, input logic fl, input logic bv, input logic [2:0] bc);
      ex_valid = v; ex_opcode = op; alu_flags = af;
      stall = st; flush = fl; br_valid = bv; br_cond = bc;
      #1;
   endtask

   // Advance through one rising edge and land on the next falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 4'b1000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 4'b1000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111);
      step();
      checks++;
      if (nf_taken !== 1'b0) begin errors++; $display("FAIL reset_taken_in_rst: got %b, required 0", nf_taken); end
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (nf_flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b, required 000", nf_flags); end
      checks++;
      if (nf_halt !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b, required 0", nf_halt); end
      checks++;
      if (nf_taken !== 1'b1) begin errors++; $display("FAIL reset_always_branch: got %b, required 1", nf_taken); end
   endtask

   task automatic test_masks();
      drive(1'b1, OP_SUB, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      checks++;
      if (nf_flags !== 3'b100) begin errors++; $display("FAIL sub_write: got %b, required 100", nf_flags); end
      // SUB leaving V/N set, then XOR must only touch Z
      drive(1'b1, OP_SUB, 3'b011, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      drive(1'b1, OP_XOR, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      checks++;
      if (nf_flags !== 3'b111) begin errors++; $display("FAIL xor_z_only: got %b, required 111", nf_flags); end
      drive(1'b1, OP_XOR, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      checks++;
      if (nf_flags !== 3'b011) begin errors++; $display("FAIL xor_clear_z: got %b, required 011", nf_flags); end
      // Non-flag opcode (LLB 1010) writes nothing
      drive(1'b1, 4'b1010, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      checks++;
      if (nf_flags !== 3'b011) begin errors++; $display("FAIL llb_no_write: got %b, required 011", nf_flags); end
      // Stall holds flags
      drive(1'b1, OP_ADD, 3'b100, 1'b1, 1'b0, 1'b0, 3'b000);
      step();
      checks++;
      if (nf_flags !== 3'b011) begin errors++; $display("FAIL stall_hold: got %b, required 011", nf_flags); end
      drive(1'b1, OP_ADD, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      idle();
      drive(1'b0, 4'b1000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b001);
      checks++;
      if (nf_taken !== 1'b1) begin errors++; $display("FAIL eq_taken: got %b, required 1", nf_taken); end
   endtask

   task automatic test_conditions();
      logic [2:0] pat [4];
      logic [7:0] exp [4];
      logic [7:0] e;
      pat[0] = 3'b000; exp[0] = 8'b1001_0101;
      pat[1] = 3'b100; exp[1] = 8'b1011_0010;
      pat[2] = 3'b001; exp[2] = 8'b1010_1001;
      pat[3] = 3'b010; exp[3] = 8'b1101_0101;
      for (int p = 0; p < 4; p++) begin
         drive(1'b1, OP_ADD, pat[p], 1'b0, 1'b0, 1'b0, 3'b000);
         step();
         e = exp[p];
         for (int c = 0; c < 8; c++) begin
            drive(1'b0, 4'b1000, 3'b000, 1'b0, 1'b0, 1'b1, 3'(c));
            checks++;
            if (nf_taken !== e[c]) begin
               errors++;
               $display("FAIL cond flags=%b cc=%0d: got %b, required %b", pat[p], c, nf_taken, e[c]);
            end
         end
      end
   endtask

   task automatic test_hazard();
      drive(1'b1, OP_ADD, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      drive(1'b1, OP_XOR, 3'b000, 1'b0, 1'b0, 1'b1, 3'b110);
      checks++;
      if (nf_haz !== 1'b1 || nf_taken !== 1'b0) begin
         errors++; $display("FAIL hazard_ov: got haz=%b taken=%b, required haz=1 taken=0", nf_haz, nf_taken);
      end
      checks++;
      if (fw_haz !== 1'b0 || fw_taken !== 1'b1) begin
         errors++; $display("FAIL fwd_ov: got haz=%b taken=%b, required haz=0 taken=1", fw_haz, fw_taken);
      end
      // Stalled EX write still blocks the branch
      drive(1'b1, OP_XOR, 3'b000, 1'b1, 1'b0, 1'b1, 3'b110);
      checks++;
      if (nf_haz !== 1'b1) begin errors++; $display("FAIL hazard_stalled: got %b, required 1", nf_haz); end
      // Flushed write never blocks
      drive(1'b1, OP_XOR, 3'b000, 1'b0, 1'b1, 1'b1, 3'b110);
      checks++;
      if (nf_haz !== 1'b0 || nf_taken !== 1'b1) begin
         errors++; $display("FAIL hazard_flushed: got haz=%b taken=%b, required haz=0 taken=1", nf_haz, nf_taken);
      end
      drive(1'b1, OP_XOR, 3'b000, 1'b0, 1'b0, 1'b1, 3'b110);
      step();
      drive(1'b0, 4'b1000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b110);
      checks++;
      if (nf_haz !== 1'b0 || nf_taken !== 1'b1) begin
         errors++; $display("FAIL after_hazard_ov: got haz=%b taken=%b, required haz=0 taken=1", nf_haz, nf_taken);
      end
   endtask

   task automatic test_forward();
      do_reset();
      drive(1'b1, OP_ADD, 3'b001, 1'b0, 1'b0, 1'b1, 3'b011);
      checks++;
      if (fw_haz !== 1'b0 || fw_taken !== 1'b1) begin
         errors++; $display("FAIL fwd_lt: got haz=%b taken=%b, required haz=0 taken=1", fw_haz, fw_taken);
      end
      checks++;
      if (nf_haz !== 1'b1 || nf_taken !== 1'b0) begin
         errors++; $display("FAIL nofwd_lt: got haz=%b taken=%b, required haz=1 taken=0", nf_haz, nf_taken);
      end
      step();
      idle();
      checks++;
      if (fw_flags !== 3'b001 || nf_flags !== 3'b001) begin
         errors++; $display("FAIL back_to_back_flags: got fw=%b nf=%b, required 001", fw_flags, nf_flags);
      end
   endtask

   task automatic test_halt();
      drive(1'b1, OP_HLT, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000);
      step();
      drive(1'b1, OP_HLT, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000);
      step();
      checks++;
      if (nf_halt !== 1'b0) begin errors++; $display("FAIL hlt_flushed: got %b, required 0", nf_halt); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, OP_HLT, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000);
         step();
      end
      checks++;
      if (nf_halt !== 1'b0) begin errors++; $display("FAIL hlt_stalled: got %b, required 0", nf_halt); end
      drive(1'b1, OP_HLT, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      checks++;
      if (nf_halt !== 1'b1) begin errors++; $display("FAIL hlt_retired: got %b, required 1", nf_halt); end
      drive(1'b1, OP_ADD, 3'b111, 1'b0, 1'b0, 1'b1, 3'b111);
      checks++;
      if (nf_taken !== 1'b0 || nf_haz !== 1'b0) begin
         errors++; $display("FAIL halted_branch: got taken=%b haz=%b, required 0 0", nf_taken, nf_haz);
      end
      step();
      step();
      checks++;
      if (nf_flags !== 3'b001) begin errors++; $display("FAIL halted_frozen: got %b, required 001", nf_flags); end
      checks++;
      if (nf_halt !== 1'b1) begin errors++; $display("FAIL halted_sticky: got %b, required 1", nf_halt); end
   endtask

   task automatic test_reset_override();
      do_reset();
      drive(1'b1, OP_ADD, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      rst = 1'b1;
      drive(1'b1, OP_ADD, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      rst = 1'b0;
      idle();
      checks++;
      if (nf_flags !== 3'b000) begin errors++; $display("FAIL rst_override: got %b, required 000", nf_flags); end
      checks++;
      if (nf_halt !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b, required 0", nf_halt); end
   endtask

   initial begin
      rst = 1'b1;
      ex_valid = 1'b0; ex_opcode = 4'b1000; alu_flags = 3'b000;
      stall = 1'b0; flush = 1'b0; br_valid = 1'b0; br_cond = 3'b000;
      @(negedge clk);
      test_reset();
      test_masks();
      test_conditions();
      test_hazard();
      test_forward();
      test_halt();
      test_reset_override();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
